// File: rtl/multu_hilo_ctrl.sv
// multu_hilo_ctrl: sequencer and HI/LO result register for the multu shift-add datapath.
// Handshakes requests from the issue stage, drives the datapath load/run controls,
// counts iterations, captures the product into HI/LO and services MTHI/MTLO.
module multu_hilo_ctrl #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [WIDTH-1:0]     req_a,
  input  logic [WIDTH-1:0]     req_b,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic                 mul_load,
  output logic                 mul_run,
  input  logic [2*WIDTH-1:0]   mul_prod,
  output logic [WIDTH-1:0]     hi,
  output logic [WIDTH-1:0]     lo,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, WRITE} state_t;
  typedef enum logic [1:0] {OP_MULTU = 2'b00, OP_MTHI = 2'b01, OP_MTLO = 2'b10, OP_NOP = 2'b11} op_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          load_q;
  logic          run_q;
  logic          done_q;
  logic          busy_q;

  // Strobes are registered alongside the state; flush masks them in the same cycle
  // so the datapath stops iterating and no completion is reported on an abort.
  assign mul_load  = load_q & ~flush;
  assign mul_run   = run_q  & ~flush;
  assign done      = done_q & ~flush;
  assign busy      = busy_q;
  assign req_ready = ~busy_q & ~flush;

  // Sequencer, HI/LO registers and operand latches.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      mul_a  <= '0;
      mul_b  <= '0;
      load_q <= 1'b0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else if (flush) begin
      state  <= IDLE;
      load_q <= 1'b0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            case (op_t'(req_op))
              OP_MULTU: begin
                mul_a  <= req_a;
                mul_b  <= req_b;
                state  <= LOAD;
                load_q <= 1'b1;
                busy_q <= 1'b1;
              end
              OP_MTHI: hi <= req_a;
              OP_MTLO: lo <= req_a;
              default: ;
            endcase
          end
        end
        LOAD: begin
          cnt    <= CNT_INIT;
          state  <= RUN;
          load_q <= 1'b0;
          run_q  <= 1'b1;
        end
        RUN: begin
          if (cnt == '0) begin
            state  <= WRITE;
            run_q  <= 1'b0;
            done_q <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        WRITE: begin
          hi     <= mul_prod[2*WIDTH-1:WIDTH];
          lo     <= mul_prod[WIDTH-1:0];
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multu_hilo_ctrl.sv
// Self-checking bench for multu_hilo_ctrl with a behavioural multi-cycle multiplier.
module tb_multu_hilo_ctrl;
  localparam int unsigned W  = 32;
  localparam int unsigned MC = 32;

  logic           clk = 1'b0;
  logic           reset, flush, req_valid, req_ready;
  logic [1:0]     req_op;
  logic [W-1:0]   req_a, req_b, mul_a, mul_b, hi, lo;
  logic           mul_load, mul_run, busy, done;
  logic [2*W-1:0] mul_prod;

  int checks = 0;
  int errors = 0;
  int dp_cnt = 0;
  logic [W-1:0] m_hi, m_lo;

  always #5 clk = ~clk;

  multu_hilo_ctrl #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b),
    .mul_load(mul_load), .mul_run(mul_run), .mul_prod(mul_prod),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  // Datapath stand-in: garbage while iterating, true product only after MC run cycles.
  always @(posedge clk) begin
    if (mul_load) begin
      dp_cnt   <= 0;
      mul_prod <= {$urandom, $urandom};
    end else if (mul_run) begin
      dp_cnt <= dp_cnt + 1;
      if (dp_cnt == MC - 1) mul_prod <= {32'b0, mul_a} * {32'b0, mul_b};
      else                  mul_prod <= {$urandom, $urandom};
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue_move(input string tag, input logic [1:0] op, input logic [31:0] d);
    req_valid = 1'b1; req_op = op; req_a = d; req_b = $urandom;
    #1;
    chk({tag, "_ready"}, 64'(req_ready), 64'd1);
    tick;
    req_valid = 1'b0;
    if (op == 2'b01) m_hi = d;
    else if (op == 2'b10) m_lo = d;
    chk({tag, "_hi"}, 64'(hi), 64'(m_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(m_lo));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  task automatic run_multu(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input bit hold_mtlo, input logic [31:0] mtlo_d);
    logic [63:0] p;
    int n, busy_n, rdy0_n, load_n, run_n;
    bit lo_stable;
    p = 64'(a) * 64'(b);
    req_valid = 1'b1; req_op = 2'b00; req_a = a; req_b = b;
    #1;
    chk({tag, "_ready"}, 64'(req_ready), 64'd1);
    tick;
    if (hold_mtlo) begin req_op = 2'b10; req_a = mtlo_d; end
    else req_valid = 1'b0;
    n = 1; busy_n = 0; rdy0_n = 0; load_n = 0; run_n = 0; lo_stable = 1'b1;
    while (!done && n < 200) begin
      if (busy) busy_n++;
      if (!req_ready) rdy0_n++;
      if (mul_load) load_n++;
      if (mul_run) run_n++;
      if (lo !== m_lo || hi !== m_hi) lo_stable = 1'b0;
      tick;
      n++;
    end
    if (busy) busy_n++;
    if (!req_ready) rdy0_n++;
    chk({tag, "_latency"}, 64'(n), 64'(MC + 2));
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(MC + 2));
    chk({tag, "_notready_cycles"}, 64'(rdy0_n), 64'(MC + 2));
    chk({tag, "_load_cycles"}, 64'(load_n), 64'd1);
    chk({tag, "_run_cycles"}, 64'(run_n), 64'(MC));
    chk({tag, "_hilo_held"}, 64'(lo_stable), 64'd1);
    chk({tag, "_mul_a"}, 64'(mul_a), 64'(a));
    chk({tag, "_mul_b"}, 64'(mul_b), 64'(b));
    tick;
    m_hi = p[63:32];
    m_lo = p[31:0];
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'(m_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(m_lo));
    if (hold_mtlo) begin
      chk({tag, "_mtlo_ready"}, 64'(req_ready), 64'd1);
      tick;
      req_valid = 1'b0;
      m_lo = mtlo_d;
      chk({tag, "_mtlo_lo"}, 64'(lo), 64'(m_lo));
      chk({tag, "_mtlo_hi"}, 64'(hi), 64'(m_hi));
    end
  endtask

  initial begin
    bit saw_done;
    logic [1:0] op;
    logic [31:0] ra, rb;
    reset = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_a = '0; req_b = '0;
    m_hi = '0; m_lo = '0;
    tick; tick;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_load", 64'(mul_load), 64'd0);
    chk("rst_run", 64'(mul_run), 64'd0);
    chk("rst_mul_a", 64'(mul_a), 64'd0);
    chk("rst_mul_b", 64'(mul_b), 64'd0);
    reset = 1'b1;
    tick;

    run_multu("t1", 32'h3, 32'h5, 1'b0, 32'h0);
    run_multu("t2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0);

    issue_move("t3_mthi", 2'b01, 32'hDEAD_BEEF);
    issue_move("t3_mtlo", 2'b10, 32'h1234_5678);

    run_multu("t4", 32'h0001_0003, 32'h0002_0007, 1'b1, 32'hCAFE_F00D);

    // Flush in RUN cycle 10.
    issue_move("t5_mthi", 2'b01, 32'hAAAA_AAAA);
    req_valid = 1'b1; req_op = 2'b00; req_a = $urandom; req_b = $urandom;
    tick;
    req_valid = 1'b0;
    repeat (10) tick;
    chk("t5_run_before", 64'(mul_run), 64'd1);
    flush = 1'b1;
    #1;
    chk("t5_run_masked", 64'(mul_run), 64'd0);
    chk("t5_ready_flush", 64'(req_ready), 64'd0);
    tick;
    flush = 1'b0;
    #1;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_run_after", 64'(mul_run), 64'd0);
    chk("t5_ready_after", 64'(req_ready), 64'd1);
    chk("t5_hi", 64'(hi), 64'(m_hi));
    chk("t5_lo", 64'(lo), 64'(m_lo));
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) saw_done = 1'b1;
      tick;
    end
    chk("t5_no_done", 64'(saw_done), 64'd0);
    flush = 1'b1; req_valid = 1'b1; req_op = 2'b01; req_a = 32'h5555_5555;
    #1;
    chk("t5_idle_flush_ready", 64'(req_ready), 64'd0);
    tick;
    flush = 1'b0; req_valid = 1'b0;
    chk("t5_idle_flush_hi", 64'(hi), 64'(m_hi));

    // Reset during RUN.
    req_valid = 1'b1; req_op = 2'b00; req_a = 32'h1111; req_b = 32'h2222;
    tick;
    req_valid = 1'b0;
    repeat (6) tick;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_hi", 64'(hi), 64'd0);
    chk("t6_lo", 64'(lo), 64'd0);
    chk("t6_run", 64'(mul_run), 64'd0);
    run_multu("t6_mul", 32'd7, 32'd6, 1'b0, 32'h0);
    chk("t6_lo42", 64'(lo), 64'd42);

    // Randomized mix of operations against the HI/LO model.
    for (int i = 0; i < 16; i++) begin
      op = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ((i % 5) == 4) ra = 32'hFFFF_FFFF;
      if (op == 2'b00) run_multu("rnd_mul", ra, rb, 1'b0, 32'h0);
      else issue_move("rnd_mv", op, ra);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
